// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer: state encoding,
// fetch constants and a small opcode helper.
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      WAIT  = 2'd1,
      HOLD  = 2'd2,
      HALT  = 2'd3
   } state_e;

   localparam logic [15:0] NOP_INSTR     = 16'h0800;
   localparam logic [4:0]  HALT_OPCODE   = 5'b00000;
   localparam logic [15:0] PC_STEP       = 16'h0002;
   // Instructions are halfword aligned; redirect targets drop bit 0.
   localparam logic [15:0] PC_ALIGN_MASK = 16'hFFFE;

   // True when the major opcode field [15:11] encodes HALT.
   function automatic logic is_halt_op(input logic [4:0] opcode);
      return opcode == HALT_OPCODE;
   endfunction

endpackage

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder, modulo 2^16 (carry out of bit 15 discarded).
module rca_16b (
   input  logic [15:0] a_i,
   input  logic [15:0] b_i,
   output logic [15:0] sum_o
);

   logic carry;

   // Ripple the carry from bit 0 upwards, one full adder per bit.
   always_comb begin
      // NOTE: blocking assignments here are deliberate -- carry must be
      // updated in order within the loop; sequential logic uses <= instead.
      carry = 1'b0;
      sum_o = '0;
      for (int i = 0; i < 16; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives a multi-cycle instruction
// memory through an en/done handshake, holds instructions under decode
// hazards, handles redirects (including one that lands while an access is
// outstanding) and freezes on HALT.
// Optional: define FETCH_PERF_CNT_EN to add fetch_cnt / stall_cnt counters.
module fetch_ctrl #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_en,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        mem_done,
   input  logic        hazard,
   input  logic        pcsrc,
   input  logic [15:0] pc_brj,
   output logic [15:0] instr_out,
   output logic        instr_valid,
   output logic [15:0] pc_incr,
   output logic        dump,
   output logic        halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [15:0] fetch_cnt,
   output logic [15:0] stall_cnt
`endif
);

   import fetch_pkg::*;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] pend_pc_q, pend_pc_d;
   logic        squash_q, squash_d;
   logic [15:0] hold_instr_q, hold_instr_d;

   logic [15:0] pc_plus2;
   logic [15:0] target;
   logic [15:0] data_now;
   logic        deliver;
   logic        accept;

   assign target = pc_brj & PC_ALIGN_MASK;

   rca_16b u_pc_adder (
      .a_i   (pc_q),
      .b_i   (PC_STEP),
      .sum_o (pc_plus2)
   );

   // Select the instruction presented this cycle and whether one is present.
   always_comb begin
      deliver  = 1'b0;
      data_now = mem_data;
      case (state_q)
         FETCH:   deliver = mem_done;
         WAIT:    deliver = mem_done && !squash_q;
         HOLD: begin
            deliver  = 1'b1;
            data_now = hold_instr_q;
         end
         default: deliver = 1'b0;
      endcase
   end

   assign mem_en      = !rst && (state_q == FETCH || state_q == WAIT);
   assign mem_addr    = pc_q;
   assign instr_valid = !rst && deliver && !pcsrc;
   assign instr_out   = instr_valid ? data_now : NOP_INSTR;
   assign pc_incr     = pc_plus2;
   assign accept      = instr_valid && !hazard;
   assign dump        = accept && is_halt_op(data_now[15:11]);
   assign halted      = !rst && (state_q == HALT);

   // Next-state logic: redirects first, then squash resolution, then completion.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      pc_d         = pc_q;
      squash_d     = squash_q;
      pend_pc_d    = pend_pc_q;
      hold_instr_d = hold_instr_q;

      case (state_q)
         FETCH: begin
            if (pcsrc) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (!mem_done) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (pcsrc) begin
               if (mem_done) begin
                  pc_d     = target;
                  squash_d = 1'b0;
                  state_d  = FETCH;
               end else begin
                  pend_pc_d = target;
                  squash_d  = 1'b1;
               end
            end else if (mem_done && squash_q) begin
               pc_d     = pend_pc_q;
               squash_d = 1'b0;
               state_d  = FETCH;
            end
         end
         HOLD: begin
            if (pcsrc) begin
               pc_d    = target;
               state_d = FETCH;
            end
         end
         default: ; // HALT: frozen until reset
      endcase

      // A real instruction completes the same way from FETCH, WAIT or HOLD.
      if (deliver && !pcsrc) begin
         if (hazard) begin
            hold_instr_d = data_now;
            state_d      = HOLD;
         end else if (is_halt_op(data_now[15:11])) begin
            state_d = HALT;
         end else begin
            pc_d    = pc_plus2;
            state_d = FETCH;
         end
      end
   end

   // Control state and PC registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         state_q   <= FETCH;
         pc_q      <= RESET_PC;
         squash_q  <= 1'b0;
         pend_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         squash_q  <= squash_d;
         pend_pc_q <= pend_pc_d;
      end
   end

   // Hold latch for an instruction stalled by decode.
   always_ff @(posedge clk) begin
      // NOTE: no reset needed; this register is only read in HOLD, which is
      // always entered by writing it first.
      hold_instr_q <= hold_instr_d;
   end

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fetch_cnt_q;
   logic [15:0] stall_cnt_q;

   // Saturating counters; both stop naturally in HALT (no accepts, no stalls).
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (accept && fetch_cnt_q != 16'hFFFF) begin
            fetch_cnt_q <= fetch_cnt_q + 16'd1;
         end
         if ((state_q == WAIT || state_q == HOLD) && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign fetch_cnt = fetch_cnt_q;
   assign stall_cnt = stall_cnt_q;
`else
   // Performance counters not built.
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed testbench for fetch_ctrl: each step drives inputs at the falling
// edge, checks combinational outputs 1 ns later, and lets the rising edge commit.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        mem_en;
   logic [15:0] mem_addr;
   logic [15:0] mem_data = '0;
   logic        mem_done = 1'b0;
   logic        hazard = 1'b0;
   logic        pcsrc = 1'b0;
   logic [15:0] pc_brj = '0;
   logic [15:0] instr_out;
   logic        instr_valid;
   logic [15:0] pc_incr;
   logic        dump;
   logic        halted;

   int checks = 0;
   int errors = 0;

   fetch_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .mem_en      (mem_en),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_done    (mem_done),
      .hazard      (hazard),
      .pcsrc       (pcsrc),
      .pc_brj      (pc_brj),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .pc_incr     (pc_incr),
      .dump        (dump),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic r, input logic done, input logic [15:0] data,
                       input logic hz, input logic ps, input logic [15:0] brj);
      @(negedge clk);
      rst      = r;
      mem_done = done;
      mem_data = data;
      hazard   = hz;
      pcsrc    = ps;
      pc_brj   = brj;
      #1;
   endtask

   initial begin
      // Reset cycle
      step(1, 1, 16'h1234, 0, 0, 0);
      check("rst_mem_en", mem_en, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr_out, 16'h0800);
      check("rst_dump", dump, 0);
      check("rst_halted", halted, 0);

      // Zero-wait fetches at 0, 2, 4
      step(0, 1, 16'h4001, 0, 0, 0);
      check("zw0_en", mem_en, 1);
      check("zw0_addr", mem_addr, 16'h0000);
      check("zw0_valid", instr_valid, 1);
      check("zw0_instr", instr_out, 16'h4001);
      check("zw0_incr", pc_incr, 16'h0002);
      step(0, 1, 16'h4002, 0, 0, 0);
      check("zw1_addr", mem_addr, 16'h0002);
      check("zw1_incr", pc_incr, 16'h0004);
      step(0, 1, 16'h4003, 0, 0, 0);
      check("zw2_addr", mem_addr, 16'h0004);
      check("zw2_incr", pc_incr, 16'h0006);

      // Access completing after 3 wait cycles at pc 6
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 16'hDEAD, 0, 0, 0);
         check("wt_en", mem_en, 1);
         check("wt_addr", mem_addr, 16'h0006);
         check("wt_valid", instr_valid, 0);
         check("wt_instr", instr_out, 16'h0800);
      end
      step(0, 1, 16'h4004, 0, 0, 0);
      check("wt_done_addr", mem_addr, 16'h0006);
      check("wt_done_valid", instr_valid, 1);
      check("wt_done_instr", instr_out, 16'h4004);

      // Redirect to 0x0041 during WAIT at pc 8
      step(0, 0, 16'h0, 0, 0, 0);
      check("sq_addr", mem_addr, 16'h0008);
      step(0, 0, 16'h0, 0, 1, 16'h0041);
      check("sq_redir_valid", instr_valid, 0);
      check("sq_redir_addr", mem_addr, 16'h0008);
      step(0, 1, 16'h4005, 0, 0, 0);
      check("sq_done_valid", instr_valid, 0);
      check("sq_done_instr", instr_out, 16'h0800);
      check("sq_done_en", mem_en, 1);
      step(0, 0, 16'h0, 0, 0, 0);
      check("sq_next_addr", mem_addr, 16'h0040);

      // Two redirects during the same WAIT: last one wins
      step(0, 0, 16'h0, 0, 1, 16'h0100);
      step(0, 0, 16'h0, 0, 1, 16'h0080);
      step(0, 1, 16'h4006, 0, 0, 0);
      check("sq2_done_valid", instr_valid, 0);
      check("sq2_done_addr", mem_addr, 16'h0040);

      // Hazard on delivered 0x4123 at pc 0x80, held 2 cycles
      step(0, 1, 16'h4123, 1, 0, 0);
      check("sq2_next_addr", mem_addr, 16'h0080);
      check("hz0_valid", instr_valid, 1);
      check("hz0_instr", instr_out, 16'h4123);
      step(0, 0, 16'hBEEF, 1, 0, 0);
      check("hz1_en", mem_en, 0);
      check("hz1_valid", instr_valid, 1);
      check("hz1_instr", instr_out, 16'h4123);
      check("hz1_incr", pc_incr, 16'h0082);
      step(0, 0, 16'hBEEF, 0, 0, 0);
      check("hz2_en", mem_en, 0);
      check("hz2_instr", instr_out, 16'h4123);
      step(0, 0, 16'h0, 0, 0, 0);
      check("hz_after_addr", mem_addr, 16'h0082);
      step(0, 1, 16'h4007, 0, 0, 0);
      check("hz_after_instr", instr_out, 16'h4007);

      // Redirect to 0xFFFF with same-cycle done: data dropped, target 0xFFFE
      step(0, 1, 16'h4008, 0, 1, 16'hFFFF);
      check("wr_redir_addr", mem_addr, 16'h0084);
      check("wr_redir_valid", instr_valid, 0);
      check("wr_redir_instr", instr_out, 16'h0800);
      step(0, 1, 16'h4009, 0, 0, 0);
      check("wr_addr", mem_addr, 16'hFFFE);
      check("wr_incr", pc_incr, 16'h0000);
      check("wr_valid", instr_valid, 1);

      // HALT delivered with a same-cycle redirect: wrong-path, no dump
      step(0, 1, 16'h0000, 0, 1, 16'h0010);
      check("hr_addr", mem_addr, 16'h0000);
      check("hr_valid", instr_valid, 0);
      check("hr_dump", dump, 0);

      // HALT at target under hazard, retired from HOLD
      step(0, 1, 16'h0000, 1, 0, 0);
      check("hh_addr", mem_addr, 16'h0010);
      check("hh_valid", instr_valid, 1);
      check("hh_dump_stalled", dump, 0);
      step(0, 0, 16'h0, 0, 0, 0);
      check("hh_dump", dump, 1);
      check("hh_instr", instr_out, 16'h0000);
      step(0, 0, 16'h0, 0, 1, 16'h0200);
      check("hlt_halted", halted, 1);
      check("hlt_en", mem_en, 0);
      check("hlt_valid", instr_valid, 0);
      check("hlt_dump_once", dump, 0);
      step(0, 1, 16'h4010, 0, 0, 0);
      check("hlt_pcsrc_ignored", mem_addr, 16'h0010);
      check("hlt_en_still", mem_en, 0);

      // Reset exits HALT
      step(1, 0, 16'h0, 0, 0, 0);
      check("hrst_halted", halted, 0);
      step(0, 1, 16'h0001, 0, 0, 0);
      check("hrst_addr", mem_addr, 16'h0000);
      check("hrst_en", mem_en, 1);
      // HALT (opcode 00000) delivered directly with hazard=0
      check("hd_valid", instr_valid, 1);
      check("hd_dump", dump, 1);
      step(0, 1, 16'h4011, 0, 0, 0);
      check("hd_halted", halted, 1);
      check("hd_dump_once", dump, 0);
      check("hd_en", mem_en, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
